// File: rtl/sopc_gpio_pkg.sv
// Shared constants and types for the SOPC GPIO peripheral.
package sopc_gpio_pkg;

    // Word offsets decoded from addr_i[4:2]
    localparam logic [2:0] GPIO_IN   = 3'd0;
    localparam logic [2:0] GPIO_OUT  = 3'd1;
    localparam logic [2:0] GPIO_DIR  = 3'd2;
    localparam logic [2:0] GPIO_IEN  = 3'd3;
    localparam logic [2:0] GPIO_RISE = 3'd4;
    localparam logic [2:0] GPIO_FALL = 3'd5;
    localparam logic [2:0] GPIO_PEND = 3'd6;
    localparam logic [2:0] GPIO_RSVD = 3'd7;

    // Decoded register index; encoding matches the offsets above
    typedef enum logic [2:0] {
        REG_IN   = 3'd0,
        REG_OUT  = 3'd1,
        REG_DIR  = 3'd2,
        REG_IEN  = 3'd3,
        REG_RISE = 3'd4,
        REG_FALL = 3'd5,
        REG_PEND = 3'd6,
        REG_RSVD = 3'd7
    } gpio_reg_e;

    // Reset polarity, same sense as the core's RstEnable/RstDisable
    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    // Expand the four byte enables into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int n = 0; n < 4; n++) begin
            m[8*n +: 8] = {8{sel[n]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser for asynchronous pad inputs.
module gpio_sync
    import sopc_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift the pad value through SYNC_STAGES flops; the last stage is the usable copy
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sopc_gpio.sv
// Memory-mapped GPIO with per-channel direction, edge interrupts and a level IRQ.
module sopc_gpio
    import sopc_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic             we_i,
    input  logic [4:0]       addr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             int_o
);

    // Warm-up spans the synchroniser fill plus one cycle for prev to catch up
    localparam int               CNT_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] pend_q;
    logic             int_q;
    logic [CNT_W-1:0] warm_cnt;

    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] pend_clr;
    logic [WIDTH-1:0] pend_nxt;
    logic [31:0]      lane_bits;
    logic [31:0]      rd_word;
    logic             warm_done;
    logic             wr_en;
    gpio_reg_e        reg_idx;

    // Byte-lane merge of a write into an implemented register
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                               input logic [WIDTH-1:0] new_v,
                                               input logic [WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign reg_idx   = gpio_reg_e'(addr_i[4:2]);
    assign wr_en     = ce_i & we_i;
    assign lane_bits = lane_mask(sel_i);
    assign wr_data   = data_i[WIDTH-1:0];
    assign wr_mask   = lane_bits[WIDTH-1:0];
    assign warm_done = (warm_cnt == WARM_DONE);

    // Byte-offset bits and write bits above WIDTH carry no meaning here
    logic unused_bits;
    assign unused_bits = &{1'b0, addr_i[1:0], data_i, lane_bits};

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_i),
        .q   (in_sync)
    );

    // Edge events and write-one-to-clear merge here; an edge in the same cycle beats the clear
    always_comb begin
        edge_hit = '0;
        if (warm_done) begin
            edge_hit = (in_sync & ~prev_q & rise_q) | (~in_sync & prev_q & fall_q);
        end
        pend_clr = '0;
        if (wr_en && (reg_idx == REG_PEND)) begin
            pend_clr = wr_data & wr_mask;
        end
        pend_nxt = (pend_q & ~pend_clr) | edge_hit;
    end

    // Register file, edge history, warm-up counter and registered interrupt line
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            prev_q   <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pend_q   <= '0;
            int_q    <= 1'b0;
            warm_cnt <= '0;
        end else begin
            prev_q <= in_sync;
            pend_q <= pend_nxt;
            int_q  <= |(pend_q & ien_q);
            if (!warm_done) begin
                warm_cnt <= warm_cnt + CNT_W'(1);
            end
            if (wr_en) begin
                case (reg_idx)
                    REG_OUT:  out_q  <= merge(out_q,  wr_data, wr_mask);
                    REG_DIR:  dir_q  <= merge(dir_q,  wr_data, wr_mask);
                    REG_IEN:  ien_q  <= merge(ien_q,  wr_data, wr_mask);
                    REG_RISE: rise_q <= merge(rise_q, wr_data, wr_mask);
                    REG_FALL: fall_q <= merge(fall_q, wr_data, wr_mask);
                    default:  ;
                endcase
            end
        end
    end

    // Zero-wait read mux; idle and write cycles return 0
    always_comb begin
        rd_word = '0;
        if (ce_i && !we_i) begin
            case (reg_idx)
                REG_IN:   rd_word[WIDTH-1:0] = in_sync;
                REG_OUT:  rd_word[WIDTH-1:0] = out_q;
                REG_DIR:  rd_word[WIDTH-1:0] = dir_q;
                REG_IEN:  rd_word[WIDTH-1:0] = ien_q;
                REG_RISE: rd_word[WIDTH-1:0] = rise_q;
                REG_FALL: rd_word[WIDTH-1:0] = fall_q;
                REG_PEND: rd_word[WIDTH-1:0] = pend_q;
                default:  rd_word = '0;
            endcase
        end
    end

    assign data_o  = rd_word;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign int_o   = int_q;

endmodule

// File: doc/sopc_gpio.md
Name: sopc_gpio

Overview:
- Parametrised memory-mapped GPIO peripheral for the OpenMIPS minimal SOPC.
- Replaces the fixed 8-bit D/o port pair with WIDTH bidirectional channels.
- Adds per-channel direction, input synchronisation, edge-triggered interrupts and a level interrupt line to the core's int_i.
- Sits on the SOPC data bus beside data RAM, selected by the SOPC address decoder.

Parameters:
- WIDTH, 8, number of GPIO channels, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- ce_i  input  1  peripheral select from SOPC decoder
- we_i  input  1  1 = write, 0 = read; valid only with ce_i
- addr_i  input  5  byte offset; only [4:2] decoded, [1:0] ignored
- sel_i  input  4  byte enables for writes
- data_i  input  32  write data
- data_o  output  32  read data
- gpio_i  input  WIDTH  pad inputs, asynchronous
- gpio_o  output  WIDTH  pad output values
- gpio_oe  output  WIDTH  pad output enables, 1 = drive
- int_o  output  1  interrupt request to core

Behaviour:
- Register map at word offsets addr_i[4:2]:
  - 0 IN, RO: synchronised gpio_i.
  - 1 OUT, RW.
  - 2 DIR, RW: 1 = output.
  - 3 IEN, RW.
  - 4 RISE, RW: rising-edge enable.
  - 5 FALL, RW: falling-edge enable.
  - 6 PEND, RW1C.
  - 7 reserved: reads 0, writes ignored.
- Register bits [WIDTH-1:0] are implemented. Upper bits read 0 and are ignored on write.
- Reset values: all registers 0, all synchroniser flops 0, data_o 0, gpio_o 0, gpio_oe 0 (all inputs), int_o 0.
- Reads:
  - Combinational, zero wait state.
  - data_o = selected register when ce_i=1 and we_i=0, else 0.
  - sel_i is ignored on reads.
- Writes:
  - Take effect at the clk edge when ce_i=1 and we_i=1.
  - Byte lane n updates only if sel_i[n]=1.
  - The new value is visible on reads and on outputs from the next cycle.
- Outputs: gpio_o = OUT, gpio_oe = DIR, both direct from registers.
- Synchroniser: SYNC_STAGES flops per bit. IN = last stage. Latency from gpio_i change to IN is SYNC_STAGES cycles.
- Edge detect:
  - prev = IN delayed by one cycle.
  - rise = IN & ~prev; fall = ~IN & prev.
  - A PEND bit sets when (rise & RISE) | (fall & FALL), regardless of IEN and DIR.
- Warm-up: a counter of SYNC_STAGES+1 cycles after reset release suppresses edge detection. A pad held high through reset raises no spurious rise.
- PEND write:
  - Writing 1 clears the bit; writing 0 has no effect.
  - If a new edge and a W1C hit the same bit in the same cycle, the set wins and the bit stays 1.
- int_o = |(PEND & IEN), registered (one cycle after PEND/IEN change). It is level-sensitive and held until software clears it.
- Writes to IN or offset 7 are discarded with no side effect.
- Reset mid-transaction: all state is cleared immediately, any in-flight write is lost, and warm-up restarts on release.

Decomposition:
- Package sopc_gpio_pkg holds:
  - The offset constants GPIO_IN..GPIO_PEND as 3-bit values.
  - A typedef for the decoded register index.
  - Reset-polarity constants consistent with the RstEnable/RstDisable macros.
- One sub-module, gpio_sync: a parametrised WIDTH×SYNC_STAGES synchroniser with asynchronous active-low reset.
- Edge logic, registers and bus decode stay in sopc_gpio.

Test Plan:
1. Reset and defaults: hold rst=0 for 195 ns, then release. Read offsets 0–7 → all 0; gpio_oe=0, int_o=0.
2. Byte-lane write: write OUT=0x000000A5 with sel=4'b0001, then DIR=0xFF. → gpio_o=0xA5, gpio_oe=0xFF next cycle. Then write OUT=0x5A with sel=0 → OUT stays 0xA5.
3. Input latency: drive gpio_i 0x00→0x3C with SYNC_STAGES=2. → Reading IN returns 0x3C exactly 2 clk after the change, and 0x00 before that.
4. Edge IRQ:
   - Setup: RISE=0x01, FALL=0x02, IEN=0x03.
   - Pulse gpio_i[0] and gpio_i[1] high then low. → PEND=0x03.
   - int_o rises one cycle after the PEND bit sets.
   - Write PEND=0x01 → PEND=0x02, int_o still 1. Write PEND=0x02 → int_o=0.
5. Set-wins race: schedule a rise on bit 0 so PEND[0] sets in the same cycle as a PEND=0x01 write. → PEND[0]=1 afterwards.
6. Warm-up and mid-run reset: hold gpio_i=0xFF across reset with RISE=0xFF restored after release. → PEND stays 0. Assert rst mid-write of OUT → OUT=0 and gpio_oe=0 immediately.
